// File: rtl/cpu_pkg.sv
// Shared types and default sizing for the data-memory stall controller.
package cpu_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_TIMEOUT    = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/wait_timer.sv
// Counts BUSY cycles since the last clear; expired flags the TIMEOUT-th enabled cycle.
module wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Saturating counter so it never wraps past TIMEOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CW'(TIMEOUT))) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_stall_ctrl.sv
// Data-memory access controller that freezes the pipeline while an external access is in flight.
// Optional macro DMEM_TIMEOUT_EN adds a wait_timer that aborts an unanswered access and sets err.
module dmem_stall_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [ADDR_WIDTH-1:0] addrM,
  input  logic [DATA_WIDTH-1:0] wdataM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] rdataM,
  output logic                  stop,
  output logic                  err
);

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("dmem_stall_ctrl: TIMEOUT must be nonzero");
  end

  dmem_state_e           state, state_d;
  logic                  access;
  logic                  stop_c;
  logic                  req_d, we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d, rdata_d;

  assign access = MemReadM | MemWriteM;

`ifdef DMEM_TIMEOUT_EN
  logic timer_clear;
  logic timed_out;
  logic err_d;

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .enable  (state == ST_BUSY),
    .expired (timed_out)
  );
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    req_d   = mem_req;
    we_d    = mem_we;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    rdata_d = rdataM;
    stop_c  = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    timer_clear = 1'b0;
    err_d       = err;
`endif
    case (state)
      ST_IDLE: begin
        stop_c = access;
        if (access) begin
          state_d = ST_BUSY;
          req_d   = 1'b1;
          we_d    = MemWriteM;
          addr_d  = addrM;
          wdata_d = wdataM;
`ifdef DMEM_TIMEOUT_EN
          timer_clear = 1'b1;
`endif
        end
      end
      ST_BUSY: begin
        stop_c = 1'b1;
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = ST_DONE;
          if (!mem_we) begin
            rdata_d = mem_rdata;
          end
        end
`ifdef DMEM_TIMEOUT_EN
        else if (timed_out) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdataM    <= '0;
    end else begin
      state     <= state_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      rdataM    <= rdata_d;
    end
  end

`ifdef DMEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= err_d;
    end
  end
`else
  assign err = 1'b0;
`endif

  // Freeze must not leak out while reset is held, even if a request is pending upstream.
  assign stop = stop_c & rst_n;

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Scoreboard bench for dmem_stall_ctrl; define DMEM_TIMEOUT_EN to also exercise the timeout path.
module tb_dmem_stall_ctrl;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          MemReadM, MemWriteM;
  logic [AW-1:0] addrM;
  logic [DW-1:0] wdataM;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] rdataM;
  logic          stop, err;

  dmem_stall_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MemReadM  (MemReadM),
    .MemWriteM (MemWriteM),
    .addrM     (addrM),
    .wdataM    (wdataM),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .rdataM    (rdataM),
    .stop      (stop),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    int            busy;
  } exp_t;

  exp_t          sb[$];
  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] exp_rdata = '0;
  logic          err_model = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One access from an IDLE negedge through DONE, returning at the following IDLE negedge.
  task automatic access(input logic rd, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                        input int waits, input bit no_ack, input bit ack_in_done);
    exp_t e;
    int   busy;
    bit   done;
    if (rd && !wr && !no_ack) exp_rdata = rdata;
    if (no_ack) err_model = 1'b1;
    e.we = wr; e.addr = addr; e.wdata = wdata; e.rdata = exp_rdata;
    e.err = err_model; e.busy = no_ack ? int'(TO) : waits + 1;
    sb.push_back(e);
    MemReadM = rd; MemWriteM = wr; addrM = addr; wdataM = wdata;
    #1 check_eq("stop_idle", 32'(stop), 32'(1));
    busy = 0;
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!mem_req) begin
        done = 1'b1;
      end else begin
        busy++;
        check_eq("busy_we",    32'(mem_we),    32'(sb[0].we));
        check_eq("busy_addr",  32'(mem_addr),  32'(sb[0].addr));
        check_eq("busy_wdata", 32'(mem_wdata), 32'(sb[0].wdata));
        check_eq("busy_stop",  32'(stop),      32'(1));
        if (!no_ack && busy == waits + 1) begin
          mem_ack = 1'b1;
          mem_rdata = rdata;
        end
      end
    end
    check_eq("busy_bound", 32'(done), 32'(1));
    e = sb.pop_front();
    check_eq("req_cycles", 32'(busy),   32'(e.busy));
    check_eq("stop_done",  32'(stop),   32'(0));
    check_eq("rdata_done", 32'(rdataM), 32'(e.rdata));
    check_eq("err_done",   32'(err),    32'(e.err));
    MemReadM = 1'b0;
    MemWriteM = 1'b0;
    if (ack_in_done) begin
      mem_ack = 1'b1;
      mem_rdata = ~rdata;
      @(negedge clk);
      mem_ack = 1'b0;
      check_eq("ack_done_rdata", 32'(rdataM),  32'(e.rdata));
      check_eq("ack_done_req",   32'(mem_req), 32'(0));
    end else begin
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    MemReadM = 1'b1; MemWriteM = 1'b0; addrM = '0; wdataM = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #1 check_eq("stop_in_reset", 32'(stop), 32'(0));
    @(negedge clk);
    MemReadM = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_req",   32'(mem_req),   32'(0));
    check_eq("rst_we",    32'(mem_we),    32'(0));
    check_eq("rst_addr",  32'(mem_addr),  32'(0));
    check_eq("rst_wdata", 32'(mem_wdata), 32'(0));
    check_eq("rst_rdata", 32'(rdataM),    32'(0));
    check_eq("rst_err",   32'(err),       32'(0));
    check_eq("rst_stop",  32'(stop),      32'(0));

    // Ack while IDLE must be ignored.
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    mem_ack = 1'b0;
    check_eq("idle_ack_req",   32'(mem_req), 32'(0));
    check_eq("idle_ack_rdata", 32'(rdataM),  32'(0));

    access(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 0, 1'b0, 1'b0);
    access(1'b0, 1'b1, 16'h0020, 16'h1234, 16'hFFFF, 4, 1'b0, 1'b0);
    access(1'b1, 1'b1, 16'h0030, 16'h5555, 16'hAAAA, 1, 1'b0, 1'b1);
    access(1'b1, 1'b0, 16'h0040, 16'h0000, 16'h1111, 0, 1'b0, 1'b0);
    access(1'b1, 1'b0, 16'h0042, 16'h0000, 16'h2222, 0, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      logic rd, wr;
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      access(rd, wr, 16'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 5)), 1'b0, 1'b0);
    end

`ifdef DMEM_TIMEOUT_EN
    access(1'b1, 1'b0, 16'h0050, 16'h0000, 16'h9999, 0, 1'b1, 1'b0);
    access(1'b1, 1'b0, 16'h0052, 16'h0000, 16'h3333, 2, 1'b0, 1'b0);
    access(1'b0, 1'b1, 16'h0054, 16'h4444, 16'h0000, 0, 1'b0, 1'b0);
`endif

    // Reset on the second BUSY cycle abandons the access.
    MemReadM = 1'b1; addrM = 16'h0060;
    @(negedge clk);
    check_eq("mid_busy1_req", 32'(mem_req), 32'(1));
    @(negedge clk);
    rst_n = 1'b0;
    MemReadM = 1'b0;
    #1;
    check_eq("mid_rst_req",  32'(mem_req), 32'(0));
    check_eq("mid_rst_stop", 32'(stop),    32'(0));
    check_eq("mid_rst_err",  32'(err),     32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    @(negedge clk);
    mem_ack = 1'b0;
    check_eq("late_ack_req",   32'(mem_req), 32'(0));
    check_eq("late_ack_rdata", 32'(rdataM),  32'(0));
    check_eq("late_ack_stop",  32'(stop),    32'(0));
    exp_rdata = '0;
    err_model = 1'b0;
    access(1'b1, 1'b0, 16'h0070, 16'h0000, 16'hC0DE, 1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_stall_ctrl.md
DMEM_STALL_CTRL -- requirements
Module: dmem_stall_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_WIDTH, 16, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, 16, data word width.
REQ-003 SHALL have parameter TIMEOUT, 15, maximum BUSY cycles without mem_ack.
REQ-004 SHALL have ports (name, direction, width, meaning): clk  in  1  single clock, rising edge.
REQ-005 SHALL have rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have MemReadM  in  1  MEM-stage load request.
REQ-007 SHALL have MemWriteM  in  1  MEM-stage store request.
REQ-008 SHALL have addrM  in  ADDR_WIDTH  MEM-stage address.
REQ-009 SHALL have wdataM  in  DATA_WIDTH  MEM-stage store data.
REQ-010 SHALL have mem_req  out  1  external request, held until ack.
REQ-011 SHALL have mem_we  out  1  external write enable.
REQ-012 SHALL have mem_addr  out  ADDR_WIDTH  latched address.
REQ-013 SHALL have mem_wdata  out  DATA_WIDTH  latched store data.
REQ-014 SHALL have mem_ack  in  1  external completion, one-cycle pulse.
REQ-015 SHALL have mem_rdata  in  DATA_WIDTH  external read data, valid with mem_ack.
REQ-016 SHALL have rdataM  out  DATA_WIDTH  load result to the MEM/WB register.
REQ-017 SHALL have stop  out  1  pipeline freeze request to the hazard unit.
REQ-018 SHALL have err  out  1  sticky timeout flag.

Function
REQ-019 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-020 In IDLE, access = MemReadM | MemWriteM, and stop SHALL equal access combinationally in the same cycle.
REQ-021 On access in IDLE: latch addrM/wdataM into mem_addr/mem_wdata, set mem_we = MemWriteM, set mem_req <= 1, clear the wait counter, go to BUSY.
REQ-022 If MemReadM and MemWriteM are both high, the access SHALL be treated as a write.
REQ-023 In BUSY: stop = 1, mem_req held at 1, mem_addr/mem_wdata/mem_we stable; the wait counter increments each cycle.
REQ-024 On mem_ack in BUSY: mem_req <= 0; if the access is a read, rdataM <= mem_rdata; go to DONE.
REQ-025 In DONE: stop = 0 for exactly one cycle so the pipeline advances; then go to IDLE unconditionally.
REQ-026 Minimum access latency SHALL be 3 cycles (IDLE, BUSY, DONE) with mem_ack arriving in the first BUSY cycle; back-to-back accesses SHALL each take at least 3 cycles.
REQ-027 rdataM SHALL hold its value until the next read capture and SHALL be unchanged by writes.
REQ-028 mem_ack in IDLE or DONE SHALL be ignored.
REQ-029 The wait counter SHALL be wide enough to count to TIMEOUT without wrap.

Reset
REQ-030 Asserting rst_n low SHALL force, asynchronously: state = IDLE; mem_req, mem_we, err, stop = 0; mem_addr, mem_wdata, rdataM, counter = 0.
REQ-031 Reset during BUSY SHALL abandon the access; mem_req drops immediately and a late mem_ack after release SHALL be ignored.

Configuration
REQ-032 Macro DMEM_TIMEOUT_EN defined: when the counter reaches TIMEOUT in BUSY without mem_ack, set mem_req <= 0, set err <= 1 (sticky until reset), leave rdataM unchanged, go to DONE.
REQ-033 Macro DMEM_TIMEOUT_EN undefined: BUSY waits indefinitely for mem_ack, the counter is removed, and err is tied to 0.

Structure
REQ-034 A shared package cpu_pkg SHALL hold the FSM state type, ADDR_WIDTH/DATA_WIDTH defaults and the TIMEOUT default.
REQ-035 The timeout counter SHALL be one sub-module, wait_timer (inputs: clear, enable; output: expired), instantiated only under DMEM_TIMEOUT_EN.

Verification
REQ-036 Load with zero wait: MemReadM=1, addrM=0x0010, mem_ack with mem_rdata=0xBEEF in the first BUSY cycle -> stop high for 2 cycles, rdataM=0xBEEF in DONE, stop low in DONE.
REQ-037 Store with 4 wait cycles: MemWriteM=1, addrM=0x0020, wdataM=0x1234 -> mem_req high for 5 cycles with mem_we=1 and mem_addr/mem_wdata stable; rdataM unchanged.
REQ-038 Read and write both high: MemReadM=MemWriteM=1 -> mem_we=1 and rdataM not updated.
REQ-039 Timeout (macro defined, TIMEOUT=15), no ack -> after 15 BUSY cycles mem_req=0, err=1, DONE entered; err stays 1 across later accesses until reset.
REQ-040 Reset mid-BUSY: rst_n low on the 2nd BUSY cycle -> mem_req and stop low immediately; mem_ack after release produces no rdataM change and no state change.
REQ-041 Back-to-back loads in consecutive instructions -> two distinct mem_req pulses separated by one DONE cycle with stop=0.
